// File: rtl/sctag_iq_pkg.sv
// Shared constants and types for the sctag input-queue RF controller.
package sctag_iq_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_CNT_W = 5;
  localparam logic [IQ_DEPTH-1:0] IQ_OH_RST = 16'h0001;

  typedef logic [IQ_DEPTH-1:0] iq_wl_t;
  typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

  // True when exactly one bit of the wordline vector is set.
  function automatic logic iq_is_onehot(input iq_wl_t v);
    return (v != '0) && ((v & (v - iq_wl_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/sctag_iq_ohptr.sv
// One-hot rotating pointer: rotates left by one on adv, 16'h8000 wraps to 16'h0001.
module sctag_iq_ohptr
  import sctag_iq_pkg::*;
(
  input  logic   rclk,
  input  logic   rst,
  input  logic   adv,
  output iq_wl_t ptr
);

  iq_wl_t ptr_q;
  iq_wl_t ptr_d;

  // Next pointer: rotate left when advancing, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = {ptr_q[IQ_DEPTH-2:0], ptr_q[IQ_DEPTH-1]};
    end
  end

  // Pointer register, returns to entry 0 on reset.
  always_ff @(posedge rclk) begin
    if (rst) begin
      ptr_q <= IQ_OH_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sctag_iq_rf_ctl.sv
// Pointer/flow controller feeding the 16x128 decoded-wordline RF of the sctag input queue.
// Optional protocol checker (sticky q_err) compiled only when SCTAG_IQ_ERR_CHK_EN is defined.
module sctag_iq_rf_ctl
  import sctag_iq_pkg::*;
#(
  parameter int AFULL_THRESH = 12
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        rst_tri_en,
  output logic        wr_en,
  output logic [15:0] wr_wl,
  output logic        read_en,
  output logic [15:0] rd_wl,
  output logic        dout_vld,
  output logic        empty,
  output logic        full,
  output logic        afull,
  output logic [4:0]  count,
  output logic        q_err
);

  localparam iq_cnt_t AFULL_CNT = iq_cnt_t'(AFULL_THRESH);
  localparam iq_cnt_t FULL_CNT  = iq_cnt_t'(IQ_DEPTH);

  iq_cnt_t count_q;
  iq_cnt_t count_d;
  logic    dout_vld_q;
  iq_wl_t  wr_ptr;
  iq_wl_t  rd_ptr;
  logic    push_acc;
  logic    pop_acc;

  // Flags come from registered occupancy only, so a pop in the same cycle never frees a full slot early.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign afull = (count_q >= AFULL_CNT);
  assign count = count_q;

  assign push_acc = push & ~full  & ~rst_tri_en;
  assign pop_acc  = pop  & ~empty & ~rst_tri_en;

  // Enables and gated wordlines go to the RF in the same cycle as the request.
  assign wr_en   = push_acc;
  assign read_en = pop_acc;
  assign wr_wl   = wr_ptr & {IQ_DEPTH{push_acc}};
  assign rd_wl   = rd_ptr & {IQ_DEPTH{pop_acc}};

  sctag_iq_ohptr u_wr_ptr (
    .rclk (rclk),
    .rst  (rst),
    .adv  (push_acc),
    .ptr  (wr_ptr)
  );

  sctag_iq_ohptr u_rd_ptr (
    .rclk (rclk),
    .rst  (rst),
    .adv  (pop_acc),
    .ptr  (rd_ptr)
  );

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + iq_cnt_t'(1);
      2'b01:   count_d = count_q - iq_cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy and read-valid flops; RF dout is valid the cycle after rd_wl is flopped by the macro.
  always_ff @(posedge rclk) begin
    if (rst) begin
      count_q    <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dout_vld_q <= pop_acc;
    end
  end

  assign dout_vld = dout_vld_q;

`ifdef SCTAG_IQ_ERR_CHK_EN
  logic err_q;
  logic err_d;

  // Sticky error: push into full, pop from empty, or a pointer losing one-hotness.
  always_comb begin
    err_d = err_q
          | (push & full  & ~rst_tri_en)
          | (pop  & empty & ~rst_tri_en)
          | ~iq_is_onehot(wr_ptr)
          | ~iq_is_onehot(rd_ptr);
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge rclk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign q_err = err_q;
`else
  assign q_err = 1'b0;
`endif

endmodule

// File: tb/tb_sctag_iq_rf_ctl.sv
// Directed bench for sctag_iq_rf_ctl with a small RF model and data scoreboard.
// Expects q_err behaviour matching the SCTAG_IQ_ERR_CHK_EN setting of the build.
module tb_sctag_iq_rf_ctl;

  logic        rclk;
  logic        rst;
  logic        push;
  logic        pop;
  logic        rst_tri_en;
  logic        wr_en;
  logic [15:0] wr_wl;
  logic        read_en;
  logic [15:0] rd_wl;
  logic        dout_vld;
  logic        empty;
  logic        full;
  logic        afull;
  logic [4:0]  count;
  logic        q_err;

  int errors = 0;
  int checks = 0;

  // Bench-side reference state.
  logic [15:0] mw;
  logic [15:0] mr;
  int          mcnt;
  logic        mvld;
  logic        merr;
  logic [15:0] sb[$];
  logic [15:0] din_ctr;

  // RF model: write on wr_en, read address flopped on read_en.
  logic [15:0] din;
  logic [15:0] mem [16];
  int          rd_idx_q;
  logic [15:0] dout;

  sctag_iq_rf_ctl #(.AFULL_THRESH(12)) dut (
    .rclk       (rclk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .rst_tri_en (rst_tri_en),
    .wr_en      (wr_en),
    .wr_wl      (wr_wl),
    .read_en    (read_en),
    .rd_wl      (rd_wl),
    .dout_vld   (dout_vld),
    .empty      (empty),
    .full       (full),
    .afull      (afull),
    .count      (count),
    .q_err      (q_err)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic int oh2idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge rclk) begin
    if (wr_en) mem[oh2idx(wr_wl)] <= din;
    if (read_en) rd_idx_q <= oh2idx(rd_wl);
  end
  assign dout = mem[rd_idx_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  // Registered outputs against the reference state.
  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mcnt));
    chk({tag, "_empty"}, 32'(empty), 32'(mcnt == 0));
    chk({tag, "_full"},  32'(full),  32'(mcnt == 16));
    chk({tag, "_afull"}, 32'(afull), 32'(mcnt >= 12));
    chk({tag, "_dvld"},  32'(dout_vld), 32'(mvld));
`ifdef SCTAG_IQ_ERR_CHK_EN
    chk({tag, "_qerr"},  32'(q_err), 32'(merr));
`else
    chk({tag, "_qerr"},  32'(q_err), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; rst_tri_en = 1'b0;
    @(posedge rclk); #1;
    rst = 1'b0;
    mw = 16'h0001; mr = 16'h0001; mcnt = 0; mvld = 1'b0; merr = 1'b0;
    sb.delete();
    #1;
    chk_state("rst");
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_en", 32'(read_en), 32'd0);
    chk("rst_wr_wl", 32'(wr_wl), 32'd0);
    chk("rst_rd_wl", 32'(rd_wl), 32'd0);
  endtask

  // One clock of stimulus with combinational checks before the edge and registered checks after.
  task automatic step(input string tag, input logic p, input logic q, input logic t);
    logic pa;
    logic qa;
    push = p; pop = q; rst_tri_en = t; din = din_ctr;
    #1;
    pa = p && (mcnt != 16) && !t;
    qa = q && (mcnt != 0) && !t;
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(pa));
    chk({tag, "_rd_en"}, 32'(read_en), 32'(qa));
    chk({tag, "_wr_wl"}, 32'(wr_wl), 32'(pa ? mw : 16'h0));
    chk({tag, "_rd_wl"}, 32'(rd_wl), 32'(qa ? mr : 16'h0));
    if (wr_en && read_en) chk({tag, "_noconf"}, 32'(wr_wl != rd_wl), 32'd1);
    if (pa) sb.push_back(din_ctr);
    din_ctr = din_ctr + 16'h1111;
    if ((p && mcnt == 16 && !t) || (q && mcnt == 0 && !t)) merr = 1'b1;
    @(posedge rclk); #1;
    if (pa) mw = rotl(mw);
    if (qa) mr = rotl(mr);
    mcnt = mcnt + int'(pa) - int'(qa);
    mvld = qa;
    chk_state(tag);
    if (mvld) begin
      if (sb.size() > 0) begin
        chk({tag, "_dout"}, 32'(dout), 32'(sb.pop_front()));
      end else begin
        chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end
    end
    push = 1'b0; pop = 1'b0; rst_tri_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; rst_tri_en = 1'b0;
    din = 16'h0; din_ctr = 16'h0123; rd_idx_q = 0;
    mw = 16'h0001; mr = 16'h0001; mcnt = 0; mvld = 1'b0; merr = 1'b0;
    @(posedge rclk); #1;
    do_reset();

    // Pop on empty right after reset.
    step("t2_pop_empty", 1'b0, 1'b1, 1'b0);
    chk("t2_dvld", 32'(dout_vld), 32'd0);

    // Fill with 16 pushes, then one rejected push.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; din = din_ctr; #1;
      chk("t1_wl_hand", 32'(wr_wl), 32'(16'h0001 << i));
      step("t1_push", 1'b1, 1'b0, 1'b0);
      chk("t1_afull_hand", 32'(afull), 32'(i + 1 >= 12));
    end
    chk("t1_count16", 32'(count), 32'd16);
    chk("t1_full", 32'(full), 32'd1);
    step("t1_push17", 1'b1, 1'b0, 1'b0);
    chk("t1_count_hold", 32'(count), 32'd16);

    // Count of 5, then three simultaneous push/pop cycles.
    do_reset();
    for (int i = 0; i < 5; i++) step("t3_fill", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t3_both", 1'b1, 1'b1, 1'b0);
      chk("t3_count5", 32'(count), 32'd5);
    end
    chk("t3_wptr_adv", 32'(mw), 32'h0100);
    chk("t3_rptr_adv", 32'(mr), 32'h0008);

    // 40 cycles of alternating push and pop, crossing the 8000->0001 wrap.
    for (int i = 0; i < 40; i++) begin
      step("t4_alt", (i % 2) == 0, (i % 2) == 1, 1'b0);
    end
    chk("t4_count", 32'(count), 32'd5);

    // Reach 8, hold rst_tri_en with push and pop for 4 cycles.
    for (int i = 0; i < 3; i++) step("t5_fill", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("t5_tri", 1'b1, 1'b1, 1'b1);
      chk("t5_count8", 32'(count), 32'd8);
    end
    step("t5_resume", 1'b1, 1'b1, 1'b0);
    chk("t5_dvld_resume", 32'(dout_vld), 32'd1);

    // Reach 10, accept a pop, then reset on the next edge.
    for (int i = 0; i < 2; i++) step("t6_fill", 1'b1, 1'b0, 1'b0);
    chk("t6_count10", 32'(count), 32'd10);
    step("t6_pop", 1'b0, 1'b1, 1'b0);
    do_reset();
    chk("t6_count0", 32'(count), 32'd0);
    step("t6_push_after", 1'b1, 1'b0, 1'b0);
    step("t6_pop_after", 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
